// File: rtl/onehot_request_sequencer_pkg.sv
// Shared types and helpers for the one-hot request sequencer.
package onehot_seq_pkg;

  localparam int unsigned REQ_W = 4;

  typedef enum logic {IDLE, SERVE} state_t;

  function automatic logic [2:0] popcount4(input logic [REQ_W-1:0] v);
    logic [2:0] c;
    c = '0;
    for (int unsigned i = 0; i < REQ_W; i++) begin
      c = c + {2'b00, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/priority_encoder_4.sv
// 4-bit priority encoder: one-hot of the leftmost (MSB) and rightmost (LSB) set bit.
module priority_encoder_4 (
  input  logic [3:0] data_i,
  input  logic       data_val_i,
  output logic [3:0] data_left_o,
  output logic [3:0] data_right_o,
  output logic       data_val_o
);

  logic [3:0] left_raw;
  logic [3:0] right_raw;

  always_comb begin
    left_raw = '0;
    if (data_i[3])      left_raw = 4'b1000;
    else if (data_i[2]) left_raw = 4'b0100;
    else if (data_i[1]) left_raw = 4'b0010;
    else if (data_i[0]) left_raw = 4'b0001;
  end

  // Two's-complement trick isolates the lowest set bit.
  assign right_raw = data_i & (~data_i + 4'd1);

  assign data_left_o  = data_val_i ? left_raw  : '0;
  assign data_right_o = data_val_i ? right_raw : '0;
  assign data_val_o   = data_val_i && (data_i != '0);

endmodule

// File: rtl/onehot_request_sequencer.sv
// Latches a 4-bit request vector and drains it as one-hot grants, one per
// accepted handshake, in priority order chosen by MSB_FIRST.
module onehot_request_sequencer
  import onehot_seq_pkg::*;
#(
  parameter logic MSB_FIRST = 1'b0
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [REQ_W-1:0] data_i,
  input  logic             data_val_i,
  output logic             ready_o,
  output logic [REQ_W-1:0] grant_o,
  output logic             grant_val_o,
  input  logic             grant_ready_i,
  output logic             busy_o,
  output logic [2:0]       pending_cnt_o
);

  state_t           state_q, state_d;
  logic [REQ_W-1:0] pending_q, pending_d;
  logic [2:0]       cnt_q;

  logic [REQ_W-1:0] enc_left;
  logic [REQ_W-1:0] enc_right;
  logic             enc_val_unused;
  logic [REQ_W-1:0] sel;
  logic             hs;
  logic             last;
  logic             accept;

  priority_encoder_4 u_enc (
    .data_i       (pending_q),
    .data_val_i   (pending_q != '0),
    .data_left_o  (enc_left),
    .data_right_o (enc_right),
    .data_val_o   (enc_val_unused)
  );

  assign sel         = MSB_FIRST ? enc_left : enc_right;
  assign grant_val_o = (state_q == SERVE);
  assign grant_o     = grant_val_o ? sel : '0;
  assign hs          = grant_val_o && grant_ready_i;
  assign last        = hs && (pending_q == sel);
  assign ready_o     = (state_q == IDLE) || last;
  assign accept      = data_val_i && ready_o;
  assign busy_o        = (pending_q != '0);
  assign pending_cnt_o = cnt_q;

  // An accept on the last-grant edge overrides the clear for zero-bubble reload.
  always_comb begin
    pending_d = pending_q;
    state_d   = state_q;
    if (hs) begin
      pending_d = pending_q & ~sel;
      if (last) state_d = IDLE;
    end
    if (accept) begin
      pending_d = data_i;
      state_d   = (data_i != '0) ? SERVE : IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q   <= IDLE;
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cnt_q     <= popcount4(pending_d);
    end
  end

endmodule

// File: tb/tb_onehot_request_sequencer.sv
// Scoreboard bench: LSB-first and MSB-first instances share stimulus; a model
// queues expected grants per accepted vector and a monitor pops on each handshake.
module tb_onehot_request_sequencer;

  typedef struct packed {
    logic [3:0] g;
    logic [2:0] c;
  } exp_t;

  logic       clk = 1'b0;
  logic       srst;
  logic [3:0] din;
  logic       dv;
  logic       gr;
  logic       rand_gr;
  logic       mon_en;

  logic       rdy   [2];
  logic [3:0] grant [2];
  logic       gv    [2];
  logic       busy  [2];
  logic [2:0] cnt   [2];

  exp_t q [2][$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  onehot_request_sequencer #(.MSB_FIRST(1'b0)) u_lsb (
    .clk_i(clk), .srst_i(srst), .data_i(din), .data_val_i(dv), .ready_o(rdy[0]),
    .grant_o(grant[0]), .grant_val_o(gv[0]), .grant_ready_i(gr),
    .busy_o(busy[0]), .pending_cnt_o(cnt[0])
  );

  onehot_request_sequencer #(.MSB_FIRST(1'b1)) u_msb (
    .clk_i(clk), .srst_i(srst), .data_i(din), .data_val_i(dv), .ready_o(rdy[1]),
    .grant_o(grant[1]), .grant_val_o(gv[1]), .grant_ready_i(gr),
    .busy_o(busy[1]), .pending_cnt_o(cnt[1])
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: each set bit becomes one grant, ordered by bit index; the
  // expected count is the number of bits still outstanding before that grant.
  task automatic push_vec(input logic [3:0] v);
    int   n;
    int   idx;
    exp_t e;
    n = 0;
    for (int i = 0; i < 4; i++) if (v[i]) n++;
    idx = 0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) begin
        e.g = 4'b0001 << i;
        e.c = 3'(n - idx);
        q[0].push_back(e);
        idx++;
      end
    end
    idx = 0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) begin
        e.g = 4'b0001 << i;
        e.c = 3'(n - idx);
        q[1].push_back(e);
        idx++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && !srst) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("busy_eq_val%0d", k), {7'd0, busy[k]}, {7'd0, gv[k]});
        if (!gv[k]) begin
          chk($sformatf("grant_idle%0d", k), {4'd0, grant[k]}, 8'd0);
          chk($sformatf("ready_idle%0d", k), {7'd0, rdy[k]}, 8'd1);
        end else if (q[k].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant%0d: got %0h expected none", k, grant[k]);
        end else begin
          chk($sformatf("grant%0d", k), {4'd0, grant[k]}, {4'd0, q[k][0].g});
          chk($sformatf("ready%0d", k), {7'd0, rdy[k]},
              {7'd0, (gr && q[k][0].c == 3'd1)});
          if (gr) begin
            chk($sformatf("cnt%0d", k), {5'd0, cnt[k]}, {5'd0, q[k][0].c});
            void'(q[k].pop_front());
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_gr) gr = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [3:0] v, output int waited);
    din    = v;
    dv     = 1'b1;
    waited = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rdy[0]) begin
        push_vec(v);
        step();
        dv = 1'b0;
        return;
      end
      waited++;
      step();
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: got ready=0 expected ready=1 for %b", v);
    dv = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (!busy[0] && !busy[1] && q[0].size() == 0 && q[1].size() == 0) begin
        chk("drain_q0", 8'(q[0].size()), 8'd0);
        chk("drain_q1", 8'(q[1].size()), 8'd0);
        return;
      end
      step();
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout: got %0d/%0d left expected 0", q[0].size(), q[1].size());
  endtask

  initial begin
    int w;
    srst = 1'b1; din = '0; dv = 1'b0; gr = 1'b1; rand_gr = 1'b0; mon_en = 1'b0;
    repeat (3) step();
    srst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_gv",    {7'd0, gv[k]},    8'd0);
      chk("rst_grant", {4'd0, grant[k]}, 8'd0);
      chk("rst_busy",  {7'd0, busy[k]},  8'd0);
      chk("rst_cnt",   {5'd0, cnt[k]},   8'd0);
      chk("rst_ready", {7'd0, rdy[k]},   8'd1);
    end
    mon_en = 1'b1;
    step();

    // Basic drain of 1011 in both orders.
    gr = 1'b1;
    send(4'b1011, w);
    drain();

    // Backpressure: grant must hold for three stalled cycles.
    gr = 1'b0;
    send(4'b0110, w);
    repeat (3) step();
    gr = 1'b1;
    drain();

    // Back-to-back: second vector accepted on the last-grant edge.
    send(4'b0001, w);
    send(4'b1100, w);
    chk("b2b_wait", 8'(w), 8'd0);
    @(negedge clk);
    chk("b2b_no_bubble0", {7'd0, gv[0]}, 8'd1);
    chk("b2b_no_bubble1", {7'd0, gv[1]}, 8'd1);
    step();
    drain();

    // Empty vector is accepted and dropped.
    send(4'b0000, w);
    @(negedge clk);
    chk("empty_gv",    {7'd0, gv[0]},  8'd0);
    chk("empty_ready", {7'd0, rdy[0]}, 8'd1);
    chk("empty_busy",  {7'd0, busy[1]}, 8'd0);
    step();

    // Reset after the first grant of 1111 discards the rest.
    gr = 1'b1;
    send(4'b1111, w);
    step();
    srst = 1'b1;
    gr   = 1'b0;
    step();
    srst = 1'b0;
    q[0].delete();
    q[1].delete();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("srst_gv",    {7'd0, gv[k]},  8'd0);
      chk("srst_cnt",   {5'd0, cnt[k]}, 8'd0);
      chk("srst_ready", {7'd0, rdy[k]}, 8'd1);
      chk("srst_busy",  {7'd0, busy[k]}, 8'd0);
    end
    gr = 1'b1;
    step();

    // Exhaustive sweep of all vectors.
    for (int v = 0; v < 16; v++) send(4'(v), w);
    drain();

    // Random vectors, random gaps, random backpressure.
    rand_gr = 1'b1;
    for (int n = 0; n < 60; n++) begin
      send(4'($urandom_range(0, 15)), w);
      repeat ($urandom_range(0, 2)) step();
    end
    rand_gr = 1'b0;
    gr = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/onehot_request_sequencer.md
Name: onehot_request_sequencer

Overview:
- Sequential stage directly downstream of priority_encoder_4.
- Accepts a 4-bit request vector with a valid/ready handshake and latches it.
- Drains the latched vector one request per granted cycle, highest priority first, using priority_encoder_4 to pick each grant. Each grant is emitted as a one-hot word with a valid/ready handshake.
- Sits between request collection logic and any single-grant consumer, for example a shared-resource port.

Parameters:
MSB_FIRST, 0, 0: grant order LSB-first (right encoder output); 1: MSB-first (left encoder output)

Ports:
clk_i  input  1  clock; all state updates on the rising edge
srst_i  input  1  synchronous active-high reset
data_i  input  4  request vector
data_val_i  input  1  request vector valid
ready_o  output  1  block can accept a vector this cycle
grant_o  output  4  one-hot grant, current highest-priority pending bit
grant_val_o  output  1  grant_o valid
grant_ready_i  input  1  downstream accepts grant_o this cycle
busy_o  output  1  pending vector non-empty
pending_cnt_o  output  3  popcount of pending vector, 0..4

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high; the ports are clk_i and srst_i.
- State: 4-bit register pending; FSM with states IDLE and SERVE.
- Reset values: pending=0, state=IDLE, grant_val_o=0, grant_o=0, busy_o=0, pending_cnt_o=0, ready_o=1.
- Reset wins over every other event in the same cycle.
- Reset mid-SERVE discards all pending bits; no further grants follow.
- Accept condition: data_val_i && ready_o at a rising edge.
  - data_i != 0: load pending=data_i; state becomes SERVE.
  - data_i == 0: accept and drop; state stays IDLE; no grant is ever produced.
- Latency: a vector accepted at edge N gives its first grant_val_o=1 in the cycle after edge N.
- grant_o is combinational from the pending register through priority_encoder_4.
  - data_val_i of the encoder is driven by (pending != 0).
  - MSB_FIRST selects data_left_o or data_right_o.
- grant_val_o = (state==SERVE). grant_o is 0 whenever grant_val_o is 0.
- Grant handshake: when grant_val_o && grant_ready_i, pending <= pending & ~grant_o.
- While grant_ready_i=0, grant_o and pending hold stable. Backpressure never loses or reorders bits.
- Last grant: the handshake where pending == grant_o.
  - Next state is IDLE, unless a new vector is accepted in the same cycle.
- ready_o = (state==IDLE) || (grant_val_o && grant_ready_i && pending==grant_o).
  - ready_o therefore has a combinational path from grant_ready_i.
  - A new vector can be accepted on the same edge as the last grant, giving zero-bubble back-to-back service.
  - A simultaneous accept loads data_i and overrides the clear. If that data_i is 0, the FSM goes to IDLE.
- busy_o = (pending != 0). busy_o equals grant_val_o in all reachable states.
- pending_cnt_o = popcount(pending), registered value, in the range 0..4.
- data_val_i while ready_o=0 is ignored; the upstream must hold the vector.
- FSM transitions:
  - IDLE -> SERVE on accepting a non-zero vector.
  - SERVE -> SERVE on a non-last grant, when no handshake occurs, or on a last grant with an accepted non-zero vector.
  - SERVE -> IDLE on a last grant with no accept, or with an accepted zero vector.
- Grant count: each non-zero vector produces exactly popcount(data_i) grants, strictly in priority order, with no duplicates.

Decomposition:
- Package onehot_seq_pkg holds:
  - localparam REQ_W=4;
  - typedef enum logic {IDLE, SERVE} state_t;
  - function popcount4.
- Sub-module: the existing priority_encoder_4, instantiated once. Its data_val_o is unused.
- Everything else stays flat in onehot_request_sequencer.

Test Plan:
- Reset, then data_i=4'b1011, data_val_i=1, grant_ready_i=1, MSB_FIRST=0 -> grants 0001, 0010, 1000 on three consecutive cycles. pending_cnt_o reads 3, 2, 1; busy_o drops after the third grant; ready_o=1 on the third grant cycle.
- Same stimulus with MSB_FIRST=1 -> grants 1000, 0010, 0001.
- Backpressure: data_i=4'b0110, grant_ready_i low for 3 cycles, then high -> grant_o holds 0010 with grant_val_o=1 for 3 cycles, then 0010, 0100. Bits are neither dropped nor duplicated.
- Back-to-back: during the last grant of 4'b0001, present data_i=4'b1100 with data_val_i=1 -> ready_o=1 and the vector is accepted on the same edge. The next cycle grants 0100, then 1000, with no idle cycle between vectors.
- Empty vector: data_i=4'b0000 accepted -> grant_val_o stays 0, busy_o=0, ready_o stays 1.
- Reset mid-SERVE: data_i=4'b1111, srst_i=1 after the first grant -> next cycle grant_val_o=0, pending_cnt_o=0, ready_o=1. Exhaustive sweep: all 16 vectors with MSB_FIRST=0 and MSB_FIRST=1, checked against a reference model for order and grant count.
